// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter, its interface and
// any bench or CPU model that talks to it.
//   state_t   - arbiter FSM encoding (IDLE, ACCESS, RDATA, RESP)
//   RW_*      - access-type encoding used on RWn and MRW
//   PORT_*    - requester indices (0 = CPU load/store unit, 1 = host loader)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  // With two ports the "other" port is simply the complement of the index.
  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles both requester handshakes and the memory-side bus.
//   Requester side: REQn, RWn, An, WDn (to arbiter); ACKn, RDn (from arbiter)
//   Memory side   : MEN, MRW, MA, MWD (from arbiter); MRD (to arbiter)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (both requesters plus the memory)
interface dmem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          REQ0, REQ1;
  logic          RW0,  RW1;
  logic [AW-1:0] A0,   A1;
  logic [DW-1:0] WD0,  WD1;
  logic          ACK0, ACK1;
  logic [DW-1:0] RD0,  RD1;

  logic          MEN;
  logic          MRW;
  logic [AW-1:0] MA;
  logic [DW-1:0] MWD;
  logic [DW-1:0] MRD;

  modport slave (
    input  REQ0, REQ1, RW0, RW1, A0, A1, WD0, WD1, MRD,
    output ACK0, ACK1, RD0, RD1, MEN, MRW, MA, MWD
  );

  modport master (
    output REQ0, REQ1, RW0, RW1, A0, A1, WD0, WD1, MRD,
    input  ACK0, ACK1, RD0, RD1, MEN, MRW, MA, MWD
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin chooser.
//   req0_i, req1_i - request lines of port 0 / port 1
//   pri_i          - port that wins when both request
//   gnt_valid_o    - at least one port is requesting
//   gnt_idx_o      - index of the chosen port (meaningful when gnt_valid_o)
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic pri_i,
  output logic gnt_valid_o,
  output logic gnt_idx_o
);

  assign gnt_valid_o = req0_i | req1_i;
  // Contention resolves to the priority port; otherwise the lone requester.
  assign gnt_idx_o   = (req0_i & req1_i) ? pri_i : req1_i;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported data memory between the CPU load/store
// unit (port 0) and the host loader/debug port (port 1).
//   CK   - clock, all state changes on posedge
//   RST  - asynchronous active-high reset
//   bus  - dmem_arbiter_if.slave: both request/ack handshakes + memory bus
// Each grant runs IDLE -> ACCESS -> (RDATA for reads) -> RESP -> IDLE, so a
// write takes three cycles and a read four. Read data is registered per port
// and held until that port's next read completes.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic           CK,
  input  logic           RST,
  dmem_arbiter_if.slave  bus
);

  state_t        state_q, state_d;
  logic          gnt_q,   gnt_d;
  logic          pri_q,   pri_d;
  logic          rw_q,    rw_d;
  logic [AW-1:0] a_q,     a_d;
  logic [DW-1:0] wd_q,    wd_d;
  logic [DW-1:0] rd0_q,   rd0_d;
  logic [DW-1:0] rd1_q,   rd1_d;

  logic pick_valid;
  logic pick_idx;

  rr_pick2 u_pick (
    .req0_i      (bus.REQ0),
    .req1_i      (bus.REQ1),
    .pri_i       (pri_q),
    .gnt_valid_o (pick_valid),
    .gnt_idx_o   (pick_idx)
  );

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= PORT_CPU;
      pri_q   <= PORT_CPU;
      rw_q    <= RW_READ;
      a_q     <= '0;
      wd_q    <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      pri_q   <= pri_d;
      rw_q    <= rw_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    pri_d   = pri_q;
    rw_d    = rw_q;
    a_d     = a_q;
    wd_d    = wd_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;

    unique case (state_q)
      IDLE: begin
        // Requests are only looked at here; the access parameters are
        // snapshotted so the requester may change them freely afterwards.
        if (pick_valid) begin
          state_d = ACCESS;
          gnt_d   = pick_idx;
          if (pick_idx == PORT_HOST) begin
            rw_d = bus.RW1;
            a_d  = bus.A1;
            wd_d = bus.WD1;
          end else begin
            rw_d = bus.RW0;
            a_d  = bus.A0;
            wd_d = bus.WD0;
          end
        end
      end
      ACCESS: begin
        state_d = (rw_q == RW_READ) ? RDATA : RESP;
      end
      RDATA: begin
        // Memory returns data the cycle after MEN; only the granted port's
        // register is touched.
        if (gnt_q == PORT_HOST) begin
          rd1_d = bus.MRD;
        end else begin
          rd0_d = bus.MRD;
        end
        state_d = RESP;
      end
      RESP: begin
        pri_d   = other_port(gnt_q);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory bus is driven straight from the snapshot registers, so it holds
  // its last values whenever MEN is low.
  assign bus.MEN  = (state_q == ACCESS);
  assign bus.MRW  = rw_q;
  assign bus.MA   = a_q;
  assign bus.MWD  = wd_q;

  assign bus.ACK0 = (state_q == RESP) && (gnt_q == PORT_CPU);
  assign bus.ACK1 = (state_q == RESP) && (gnt_q == PORT_HOST);
  assign bus.RD0  = rd0_q;
  assign bus.RD1  = rd1_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-ported data memory between two requesters: port 0 (CPU load/store unit) and port 1 (host loader/debug port that preloads or inspects DMEM).
- Sits between the CPU data bus (DA/DD/RW) and the memory, and serializes accesses with a request/acknowledge handshake.
- Uses fair two-way round-robin when both ports request.
- Returns read data registered with a fixed, documented latency.

## Interface

Parameters:
- AW, 16, address width.
- DW, 16, data width.

Ports:
- CK  in  1  clock, all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- REQ0 / REQ1  in  1  access request per port; held high until ACK of that port.
- RW0 / RW1  in  1  access type: 1 = read (load), 0 = write (store).
- A0 / A1  in  AW  access address.
- WD0 / WD1  in  DW  write data.
- ACK0 / ACK1  out  1  one-cycle completion pulse.
- RD0 / RD1  out  DW  read data, valid in the ACK cycle, held until the next ACK of that port.
- MEN  out  1  memory enable, one cycle per access.
- MRW  out  1  memory access type, same encoding as RWn.
- MA  out  AW  memory address.
- MWD  out  DW  memory write data.
- MRD  in  DW  memory read data; valid in the cycle after the MEN cycle.

## Operation

- FSM states: IDLE, ACCESS, RDATA, RESP.
- IDLE:
  - Samples REQ0/REQ1.
  - A single request is granted. When both request, the port named by the priority pointer PRI is granted.
  - On a grant: latches the granted port's RW, A and WD into internal registers and records the granted port in GNT. Next state is ACCESS.
  - No request: stays in IDLE.
- ACCESS:
  - MEN=1; MRW, MA, MWD are driven from the latched registers.
  - A write completes in memory at the end of this cycle.
  - Next state: RDATA if a read, otherwise RESP.
- RDATA: captures MRD into the read-data register of the GNT port. Next state is RESP.
- RESP:
  - ACKn=1 for the GNT port only.
  - PRI <= the non-granted port.
  - Next state is IDLE.
- REQ is ignored outside IDLE.
- Changes to RWn, An or WDn after the grant have no effect on the access in flight.
- A requester still holding REQ high in the cycle after its ACK is treated as a new transaction.
- PRI update rule: after every completed access, the other port gets priority. Result: under continuous contention the ports alternate 0,1,0,1…
- RD of the non-granted port is never modified.
- When MEN=0, MA, MWD and MRW hold their last values. Memory ignores them.

## Timing

- Reset (asynchronous, immediate):
  - State=IDLE, PRI=0 (port 0 wins first contention).
  - ACK0=ACK1=0, MEN=0, MRW=1, MA=0, MWD=0, RD0=RD1=0.
- Write latency: REQ seen in IDLE at edge t → MEN high cycle t+1 → ACK cycle t+2. Three cycles per write, including the return through IDLE.
- Read latency: REQ at t → MEN t+1 → MRD captured end of t+2 → ACK and RD valid cycle t+3. Four cycles per read.
- Both ports requesting in the same IDLE cycle: PRI port is served first. The other port is granted in the IDLE cycle after the first port's RESP.
- A request arriving in any non-IDLE cycle waits. It is evaluated in the next IDLE.
- RST asserted mid-access: the FSM returns to IDLE immediately and no ACK is issued. A write whose MEN cycle was already sampled by memory is complete; otherwise no memory update occurs. Requesters must re-issue.
- ACK0 and ACK1 are never high in the same cycle. At most one MEN pulse occurs per grant.

## Structure

- Shared package dmem_pkg holds:
  - state encoding (IDLE, ACCESS, RDATA, RESP);
  - RW_READ=1'b1 and RW_WRITE=1'b0;
  - port-index constants PORT_CPU=0 and PORT_HOST=1.
- The CPU and simulation benches use the same package.
- One sub-module, rr_pick2: combinational two-way round-robin chooser. Inputs: REQ0, REQ1, PRI. Outputs: grant valid and grant index.
- The FSM, latches and PRI register stay in dmem_arbiter.

## Test plan

- Reset release, port 0 writes A0=2, WD0=16'h01FE:
  - MEN=1, MRW=0, MA=2, MWD=16'h01FE two cycles after the request edge;
  - ACK0 one cycle later; ACK1 stays 0.
- Port 1 reads A1=1 with memory holding 255:
  - ACK1 and RD1=255 appear four edges after the request.
  - RD0 is unchanged.
- REQ0 and REQ1 both rise in the same cycle, both reads:
  - port 0 is acknowledged first, port 1 second.
  - Holding both requests for 6 accesses gives ACK order 0,1,0,1,0,1.
- Port 0 changes A0 and WD0 on the cycle after its grant: the memory sees the originally latched values.
- RST pulsed during the RDATA cycle of a port-1 read:
  - no ACK1 and RD1 stays at its reset value;
  - FSM is in IDLE and PRI=0;
  - a following port-1 request completes normally.
- Write to addr 2 then read addr 2 from the other port: the read returns the written value. Confirms the write landed in the single MEN cycle.
